alu_decoder: RTL and testbench

Decode-and-issue stage that drives the ALU: accepts a 32-bit RV32I instruction with its PC and register-file read data over a valid/ready handshake, decodes OP, OP-IMM, LUI and AUIPC into an `alu_op_e` operator plus two operands, and presents them from a registered output stage. Sits between fetch/register-file read and the ALU. All other opcodes are flagged illegal.

---
 rtl/alu_decoder_pkg.sv | 36 +++
 rtl/alu_decoder_if.sv | 35 +++
 rtl/alu_decoder_comb.sv | 85 ++++++++
 rtl/alu_decoder.sv | 89 ++++++++
 tb/tb_alu_decoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_decoder_pkg.sv
// Shared RV32I decode types: ALU operator enum, opcode constants and the
// decoded-instruction struct that travels from decoder to the output stage.
package rv32_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      alu_op_e     op;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } alu_dec_t;

   localparam alu_dec_t DEC_RESET = '{a: 32'd0, b: 32'd0, op: ALU_ADD,
                                      rd: 5'd0, we: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/alu_decoder_if.sv
// Issue-side bus of alu_decoder: instruction input handshake, register-file
// read port and the decoded ALU output handshake.
interface alu_decoder_if;
   import rv32_pkg::*;

   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [4:0]  rs1_addr_o;
   logic [4:0]  rs2_addr_o;
   logic [31:0] rs1_rdata_i;
   logic [31:0] rs2_rdata_i;
   logic [31:0] operand_a_o;
   logic [31:0] operand_b_o;
   alu_op_e     alu_op_o;
   logic [4:0]  rd_addr_o;
   logic        rd_we_o;
   logic        illegal_o;
   logic        out_valid_o;
   logic        out_ready_i;

   modport slave (
      input  instr_i, pc_i, instr_valid_i, rs1_rdata_i, rs2_rdata_i, out_ready_i,
      output instr_ready_o, rs1_addr_o, rs2_addr_o, operand_a_o, operand_b_o,
             alu_op_o, rd_addr_o, rd_we_o, illegal_o, out_valid_o
   );

   modport master (
      output instr_i, pc_i, instr_valid_i, rs1_rdata_i, rs2_rdata_i, out_ready_i,
      input  instr_ready_o, rs1_addr_o, rs2_addr_o, operand_a_o, operand_b_o,
             alu_op_o, rd_addr_o, rd_we_o, illegal_o, out_valid_o
   );

endinterface

// File: rtl/alu_decoder_comb.sv
// Pure combinational RV32I decode of OP / OP-IMM / LUI / AUIPC into an
// ALU operator and operands; everything else comes out flagged illegal.
module alu_dec_comb
   import rv32_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output alu_dec_t    dec
);

   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;

   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_u = {instr[31:12], 12'd0};

   always_comb begin
      dec = '{a: rs1_data, b: rs2_data, op: ALU_ADD, rd: instr[11:7],
              we: 1'b0, illegal: 1'b1};
      // Opcode constants include bits [1:0]=11, so compressed encodings miss every arm.
      case (instr[6:0])
         OPC_OP: begin
            dec.illegal = !((f7 == 7'b0000000) ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            case (f3)
               3'b000:  dec.op = f7[5] ? ALU_SUB : ALU_ADD;
               3'b001:  dec.op = ALU_SLL;
               3'b010:  dec.op = ALU_SLT;
               3'b011:  dec.op = ALU_SLTU;
               3'b100:  dec.op = ALU_XOR;
               3'b101:  dec.op = f7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  dec.op = ALU_OR;
               default: dec.op = ALU_AND;
            endcase
         end
         OPC_OP_IMM: begin
            dec.b       = imm_i;
            dec.illegal = 1'b0;
            case (f3)
               3'b000:  dec.op = ALU_ADD;
               3'b001: begin
                  dec.op      = ALU_SLL;
                  dec.illegal = (f7 != 7'b0000000);
               end
               3'b010:  dec.op = ALU_SLT;
               3'b011:  dec.op = ALU_SLTU;
               3'b100:  dec.op = ALU_XOR;
               3'b101: begin
                  dec.op      = f7[5] ? ALU_SRA : ALU_SRL;
                  dec.illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
               end
               3'b110:  dec.op = ALU_OR;
               default: dec.op = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            dec.a       = 32'd0;
            dec.b       = imm_u;
            dec.op      = ALU_PASS;
            dec.illegal = 1'b0;
         end
         OPC_AUIPC: begin
            dec.a       = pc;
            dec.b       = imm_u;
            dec.op      = ALU_ADD;
            dec.illegal = 1'b0;
         end
         default: dec.illegal = 1'b1;
      endcase

      if (dec.illegal) begin
         dec.a  = 32'd0;
         dec.b  = 32'd0;
         dec.op = ALU_ADD;
      end
      dec.we = !dec.illegal && (dec.rd != 5'd0);
   end

endmodule

// File: rtl/alu_decoder.sv
// Decode-and-issue stage: valid/ready input, registered decoded output.
// Define ALU_DECODER_SKID_EN for a one-entry skid that registers instr_ready_o.
module alu_decoder
   import rv32_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   alu_decoder_if.slave  bus
);

   alu_dec_t dec;
   alu_dec_t out_q;
   logic     out_valid;
   logic     in_hs;
   logic     out_hs;

   alu_dec_comb u_dec (
      .instr    (bus.instr_i),
      .pc       (bus.pc_i),
      .rs1_data (bus.rs1_rdata_i),
      .rs2_data (bus.rs2_rdata_i),
      .dec      (dec)
   );

   assign bus.rs1_addr_o  = bus.instr_i[19:15];
   assign bus.rs2_addr_o  = bus.instr_i[24:20];
   assign bus.operand_a_o = out_q.a;
   assign bus.operand_b_o = out_q.b;
   assign bus.alu_op_o    = out_q.op;
   assign bus.rd_addr_o   = out_q.rd;
   assign bus.rd_we_o     = out_q.we;
   assign bus.illegal_o   = out_q.illegal;
   assign bus.out_valid_o = out_valid;

   assign in_hs  = bus.instr_valid_i && bus.instr_ready_o;
   assign out_hs = out_valid && bus.out_ready_i;

`ifdef ALU_DECODER_SKID_EN
   alu_dec_t skid_q;
   logic     skid_valid;

   assign bus.instr_ready_o = !skid_valid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q      <= DEC_RESET;
         out_valid  <= 1'b0;
         skid_q     <= DEC_RESET;
         skid_valid <= 1'b0;
      end else if (flush_i) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || out_hs) begin
         // Output slot frees up: the skid entry is older, so it goes first.
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_hs) begin
            out_q     <= dec;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_hs) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end
`else
   assign bus.instr_ready_o = !out_valid || bus.out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q     <= DEC_RESET;
         out_valid <= 1'b0;
      end else if (flush_i) begin
         out_valid <= 1'b0;
      end else if (in_hs) begin
         out_q     <= dec;
         out_valid <= 1'b1;
      end else if (out_hs) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: decode vectors, stall/backpressure,
// flush and asynchronous reset, in either skid or non-skid build.
module tb_alu_decoder;
   import rv32_pkg::*;

   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   passes;

   alu_decoder_if bus ();

   alu_decoder dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
      bus.instr_i       = instr;
      bus.pc_i          = pc;
      bus.rs1_rdata_i   = r1;
      bus.rs2_rdata_i   = r2;
      bus.instr_valid_i = 1'b1;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
      drive(instr, pc, r1, r2);
      tick();
      bus.instr_valid_i = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input alu_op_e op, input logic [4:0] rd, input logic we,
                          input logic ill);
      chk({tag, ".valid"}, 32'(bus.out_valid_o), 32'd1);
      chk({tag, ".a"},     bus.operand_a_o, a);
      chk({tag, ".b"},     bus.operand_b_o, b);
      chk({tag, ".op"},    32'(bus.alu_op_o), 32'(op));
      chk({tag, ".rd"},    32'(bus.rd_addr_o), 32'(rd));
      chk({tag, ".we"},    32'(bus.rd_we_o), 32'(we));
      chk({tag, ".ill"},   32'(bus.illegal_o), 32'(ill));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid_o), 32'd0);
      chk({tag, ".a"},     bus.operand_a_o, 32'd0);
      chk({tag, ".b"},     bus.operand_b_o, 32'd0);
      chk({tag, ".op"},    32'(bus.alu_op_o), 32'(ALU_ADD));
      chk({tag, ".rd"},    32'(bus.rd_addr_o), 32'd0);
      chk({tag, ".we"},    32'(bus.rd_we_o), 32'd0);
      chk({tag, ".ill"},   32'(bus.illegal_o), 32'd0);
      chk({tag, ".rdy"},   32'(bus.instr_ready_o), 32'd1);
   endtask

   initial begin
      checks            = 0;
      passes            = 0;
      rst               = 1'b1;
      flush             = 1'b0;
      bus.instr_i       = 32'd0;
      bus.pc_i          = 32'd0;
      bus.rs1_rdata_i   = 32'd0;
      bus.rs2_rdata_i   = 32'd0;
      bus.instr_valid_i = 1'b0;
      bus.out_ready_i   = 1'b1;
      #2;
      chk_reset("reset");
      #10 rst = 1'b0;
      tick();

      // addi x1,x2,-1 ; register-file address ports are combinational
      drive(32'hFFF10093, 32'h0, 32'd5, 32'd0);
      #1;
      chk("addi.rs1_addr", 32'(bus.rs1_addr_o), 32'd2);
      chk("addi.rs2_addr", 32'(bus.rs2_addr_o), 32'd31);
      tick();
      bus.instr_valid_i = 1'b0;
      chk_out("addi", 32'd5, 32'hFFFF_FFFF, ALU_ADD, 5'd1, 1'b1, 1'b0);

      issue(32'h402081B3, 32'h0, 32'd7, 32'd10);
      chk_out("sub", 32'd7, 32'd10, ALU_SUB, 5'd3, 1'b1, 1'b0);

      issue(32'h123452B7, 32'h0, 32'hDEAD_BEEF, 32'h0);
      chk_out("lui", 32'd0, 32'h1234_5000, ALU_PASS, 5'd5, 1'b1, 1'b0);

      issue(32'h00001297, 32'h1000, 32'hDEAD_BEEF, 32'h0);
      chk_out("auipc", 32'h1000, 32'h1000, ALU_ADD, 5'd5, 1'b1, 1'b0);

      // srai x1,x1,3 : B is the raw sign-extended immediate, shamt in [4:0]
      issue(32'h4030D093, 32'h0, 32'h8000_0000, 32'h0);
      chk_out("srai", 32'h8000_0000, 32'h0000_0403, ALU_SRA, 5'd1, 1'b1, 1'b0);

      issue(32'h40109093, 32'h0, 32'd9, 32'd9);
      chk_out("slli_bad", 32'd0, 32'd0, ALU_ADD, 5'd1, 1'b0, 1'b1);

      issue(32'h00000013, 32'h0, 32'd0, 32'd0);
      chk_out("addi_x0", 32'd0, 32'd0, ALU_ADD, 5'd0, 1'b0, 1'b0);

      issue(32'h0000_0000, 32'h0, 32'd3, 32'd4);
      chk_out("zero_word", 32'd0, 32'd0, ALU_ADD, 5'd0, 1'b0, 1'b1);

      tick();
      chk("idle.valid", 32'(bus.out_valid_o), 32'd0);

      // Stall: two back-to-back inputs while downstream holds ready low
      bus.out_ready_i = 1'b0;
      drive(32'hFFF10093, 32'h0, 32'd5, 32'd0);
      tick();
      drive(32'h402081B3, 32'h0, 32'd7, 32'd10);
      #1;
`ifdef ALU_DECODER_SKID_EN
      chk("stall.rdy0", 32'(bus.instr_ready_o), 32'd1);
`else
      chk("stall.rdy0", 32'(bus.instr_ready_o), 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("stall.hold", 32'd5, 32'hFFFF_FFFF, ALU_ADD, 5'd1, 1'b1, 1'b0);
         chk("stall.rdy", 32'(bus.instr_ready_o), 32'd0);
      end
      bus.out_ready_i = 1'b1;
      #1;
`ifdef ALU_DECODER_SKID_EN
      chk("release.rdy", 32'(bus.instr_ready_o), 32'd0);
`else
      chk("release.rdy", 32'(bus.instr_ready_o), 32'd1);
`endif
      tick();
      bus.instr_valid_i = 1'b0;
      chk_out("release.second", 32'd7, 32'd10, ALU_SUB, 5'd3, 1'b1, 1'b0);
      tick();
      chk("drain.valid", 32'(bus.out_valid_o), 32'd0);

      // Flush while stalled (skid build also has an entry in the skid)
      bus.out_ready_i = 1'b0;
      drive(32'h123452B7, 32'h0, 32'd0, 32'd0);
      tick();
      drive(32'h402081B3, 32'h0, 32'd7, 32'd10);
      tick();
      bus.instr_valid_i = 1'b0;
      chk("preflush.valid", 32'(bus.out_valid_o), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush.valid", 32'(bus.out_valid_o), 32'd0);
      chk("flush.rdy", 32'(bus.instr_ready_o), 32'd1);
      bus.out_ready_i = 1'b1;
      tick();
      chk("postflush.valid", 32'(bus.out_valid_o), 32'd0);

      // Asynchronous reset in the middle of a stream
      drive(32'h402081B3, 32'h0, 32'd7, 32'd10);
      tick();
      chk("prerst.valid", 32'(bus.out_valid_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_reset("async_rst");
      bus.instr_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("postrst.valid", 32'(bus.out_valid_o), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
